// File: rtl/core_mem_requester.sv
// Per-core load/store sequencer feeding one port of the shared-RAM arbiter; HOLD+1 cycles from command to done when granted immediately.
// No queue: commands are accepted only while idle, and completion waits for the arbiter to drop its grant.
module core_mem_requester #(
  parameter int HOLD    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_rd,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  output logic       mem_rden,
  output logic       mem_wren,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_din,
  input  logic       mem_acq,
  input  logic [7:0] mem_dq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;

  // One counter serves both the grant wait and the access hold; it saturates.
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 8'd0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      mem_addr <= 8'd0;
      mem_din  <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_rd || req_wr) begin
            mem_wren <= req_wr;
            mem_rden <= ~req_wr;
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            cnt      <= 8'd0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_acq) begin
            cnt   <= 8'd0;
            state <= ACCESS;
          end else if (cnt == TMO_LAST) begin
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            state    <= RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ACCESS: begin
          // Dq reflects the held address only after the arbiter's register stages.
          if (cnt == HOLD_LAST) begin
            if (mem_rden) rdata <= mem_dq;
            mem_rden <= 1'b0;
            mem_wren <= 1'b0;
            done     <= 1'b1;
            state    <= RELEASE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          // Waiting out the old grant keeps it from satisfying the next request.
          if (!mem_acq) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_requester.sv
// Randomized bench for core_mem_requester: two instances (long and short grant timeout) checked
// against a per-transaction timing model driven by an arbiter stand-in.
module tb_core_mem_requester;

  localparam int HOLD = 3;

  logic       clk;
  logic       rst;
  logic [1:0] rd;
  logic [1:0] wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       acq;
  logic [7:0] dq;

  logic [1:0] busy_o;
  logic [1:0] done_o;
  logic [1:0] err_o;
  logic [1:0] rden_o;
  logic [1:0] wren_o;
  logic [7:0] rdata_o [2];
  logic [7:0] maddr_o [2];
  logic [7:0] mdin_o  [2];

  int         n_tests;
  int         n_fail;
  int         tmo_of  [2];
  logic [7:0] m_rdata [2];

  core_mem_requester #(.HOLD(HOLD), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .req_rd(rd[0]), .req_wr(wr[0]), .req_addr(addr), .req_wdata(wdata),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .rdata(rdata_o[0]),
    .mem_rden(rden_o[0]), .mem_wren(wren_o[0]), .mem_addr(maddr_o[0]), .mem_din(mdin_o[0]),
    .mem_acq(acq), .mem_dq(dq)
  );

  core_mem_requester #(.HOLD(HOLD), .TIMEOUT(8)) u_tmo (
    .clk(clk), .rst(rst), .req_rd(rd[1]), .req_wr(wr[1]), .req_addr(addr), .req_wdata(wdata),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .rdata(rdata_o[1]),
    .mem_rden(rden_o[1]), .mem_wren(wren_o[1]), .mem_addr(maddr_o[1]), .mem_din(mdin_o[1]),
    .mem_acq(acq), .mem_dq(dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input int sel, input string tag);
    chk({tag, " busy"},  8'(busy_o[sel]), 8'd0);
    chk({tag, " done"},  8'(done_o[sel]), 8'd0);
    chk({tag, " err"},   8'(err_o[sel]),  8'd0);
    chk({tag, " rden"},  8'(rden_o[sel]), 8'd0);
    chk({tag, " wren"},  8'(wren_o[sel]), 8'd0);
    chk({tag, " rdata"}, rdata_o[sel],    m_rdata[sel]);
    chk({tag, " addr"},  maddr_o[sel],    8'd0);
    chk({tag, " din"},   mdin_o[sel],     8'd0);
  endtask

  // One transaction on instance sel. Arbiter stand-in: grant visible gd cycles after the
  // request appears, Dq valid two cycles after grant, grant held stale cycles past done.
  // Stray commands are thrown at the DUT while it is busy and must have no effect.
  task automatic run_txn(input int sel, input bit is_wr, input logic [7:0] a, input logic [7:0] wd,
                         input int gd, input int stale, input logic [7:0] rv);
    bit         granted;
    int         done_k;
    int         rel_k;
    logic [7:0] exp_rd;
    granted = (gd + 1 <= tmo_of[sel]);
    done_k  = granted ? gd + 1 + HOLD : tmo_of[sel];
    rel_k   = done_k + (granted ? stale : 0) + 1;
    exp_rd  = (granted && !is_wr) ? rv : m_rdata[sel];
    chk("idle before cmd", 8'(busy_o[sel]), 8'd0);
    if (is_wr) wr[sel] = 1'b1;
    else       rd[sel] = 1'b1;
    addr  = a;
    wdata = wd;
    @(negedge clk);
    rd    = 2'b00;
    wr    = 2'b00;
    addr  = 8'($urandom);
    wdata = 8'($urandom);
    for (int k = 0; k <= rel_k; k++) begin
      chk("busy", 8'(busy_o[sel]), 8'(k < rel_k));
      chk("rden", 8'(rden_o[sel]), 8'(!is_wr && k < done_k));
      chk("wren", 8'(wren_o[sel]), 8'(is_wr && k < done_k));
      chk("done", 8'(done_o[sel]), 8'(k == done_k));
      if (k < done_k) begin
        chk("mem_addr", maddr_o[sel], a);
        chk("mem_din",  mdin_o[sel],  wd);
      end
      if (k == done_k) chk("err", 8'(err_o[sel]), 8'(!granted));
      chk("rdata", rdata_o[sel], (k >= done_k) ? exp_rd : m_rdata[sel]);
      acq = granted && (k >= gd) && (k < done_k + stale);
      dq  = (granted && k >= gd + 2 && k < done_k) ? rv : 8'($urandom);
      rd[sel] = (k == 1) || (k >= done_k && k < rel_k);
      if (k < rel_k) @(negedge clk);
    end
    rd           = 2'b00;
    acq          = 1'b0;
    m_rdata[sel] = exp_rd;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    tmo_of[0] = 255;
    tmo_of[1] = 8;
    rd        = 2'b00;
    wr        = 2'b00;
    addr      = 8'd0;
    wdata     = 8'd0;
    acq       = 1'b0;
    dq        = 8'd0;
    rst       = 1'b1;
    m_rdata[0] = 8'd0;
    m_rdata[1] = 8'd0;
    repeat (2) @(negedge clk);
    chk_quiet(0, "reset u_dut");
    chk_quiet(1, "reset u_tmo");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the intended usage.
    run_txn(0, 1'b0, 8'h3C, 8'h00, 0, 0, 8'hA5);
    run_txn(0, 1'b1, 8'h10, 8'h5A, 0, 0, 8'hEE);
    run_txn(0, 1'b0, 8'h21, 8'h00, 20, 0, 8'h77);
    run_txn(1, 1'b0, 8'h44, 8'h00, 1000, 0, 8'h00);
    run_txn(0, 1'b0, 8'h55, 8'h00, 0, 3, 8'hC3);
    run_txn(0, 1'b0, 8'h56, 8'h00, 3, 0, 8'h3D);
    run_txn(1, 1'b0, 8'h57, 8'h00, 7, 0, 8'h9A);

    // Reset in the middle of an access: no done, everything back to zero.
    rd[0] = 1'b1;
    addr  = 8'h77;
    @(negedge clk);
    rd[0] = 1'b0;
    acq   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    m_rdata[0] = 8'd0;
    m_rdata[1] = 8'd0;
    @(negedge clk);
    chk_quiet(0, "mid reset");
    @(negedge clk);
    chk_quiet(0, "mid reset hold");
    rst = 1'b0;
    acq = 1'b0;
    @(negedge clk);
    chk_quiet(0, "after reset");
    run_txn(0, 1'b0, 8'h12, 8'h00, 1, 0, 8'h6B);

    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(1, 0));
      run_txn(sel, 1'($urandom), 8'($urandom), 8'($urandom),
              (sel == 0) ? int'($urandom_range(25, 0)) : int'($urandom_range(12, 0)),
              int'($urandom_range(3, 0)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
